// File: rtl/coolgirl_pkg.sv
// Shared register map and IRQ mode encodings for the CoolGirl IRQ unit.
package coolgirl_pkg;

  localparam logic [2:0] REG_LATCH_LO = 3'd0;
  localparam logic [2:0] REG_LATCH_HI = 3'd1;
  localparam logic [2:0] REG_CONTROL  = 3'd2;
  localparam logic [2:0] REG_RELOAD   = 3'd3;
  localparam logic [2:0] REG_ACK      = 3'd4;

  typedef enum logic [1:0] {
    MODE_SCANLINE  = 2'd0,
    MODE_CPU       = 2'd1,
    MODE_PRESCALED = 2'd2,
    MODE_FROZEN    = 2'd3
  } irq_mode_e;

  // Bit layout matches the control register: {auto_reload, enable, mode[1:0]}.
  typedef struct packed {
    logic      autoReload;
    logic      enable;
    irq_mode_e mode;
  } irq_ctrl_t;

endpackage

// File: rtl/coolgirl_a12_filter.sv
// Synchronises raw PPU A12 into the m2 domain and emits one tick per rise
// that follows a long enough run of low samples.
module coolgirl_a12_filter #(
  parameter int A12_FILTER = 3
) (
  input  logic m2_i,
  input  logic rst_ni,
  input  logic a12_i,
  output logic tick_o
);

  localparam int LW = $clog2(A12_FILTER + 1);
  localparam logic [LW-1:0] RUN_MAX = LW'(A12_FILTER);

  logic          sync1_q;
  logic          sync2_q;
  logic [LW-1:0] lowCnt_q;
  logic [LW-1:0] lowCnt_d;

  // The run counter saturates so a long idle low period still qualifies.
  always_comb begin
    lowCnt_d = lowCnt_q;
    if (sync2_q) begin
      lowCnt_d = '0;
    end else if (lowCnt_q != RUN_MAX) begin
      lowCnt_d = lowCnt_q + LW'(1);
    end
  end

  always_ff @(posedge m2_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      lowCnt_q <= '0;
    end else begin
      sync1_q  <= a12_i;
      sync2_q  <= sync1_q;
      lowCnt_q <= lowCnt_d;
    end
  end

  assign tick_o = sync2_q && (lowCnt_q >= RUN_MAX);

endmodule

// File: rtl/coolgirl_irq_unit.sv
// CoolGirl mapper IRQ unit: scanline, CPU-cycle and prescaled counter modes
// sharing one reloadable counter and a registered pending flag.
module coolgirl_irq_unit
  import coolgirl_pkg::*;
#(
  parameter int CNT_WIDTH  = 8,
  parameter int A12_FILTER = 3,
  parameter int PRESCALE   = 341
) (
  input  logic                 m2,
  input  logic                 rst_n,
  input  logic                 reg_we,
  input  logic [2:0]           reg_sel,
  input  logic [7:0]           reg_wdata,
  input  logic                 ppu_a12,
  output logic                 irq,
  output logic [CNT_WIDTH-1:0] counter
);

  localparam int PW = $clog2(PRESCALE) + 2;
  localparam logic signed [PW-1:0] PRESC_RELOAD = PW'(PRESCALE);
  localparam logic signed [PW-1:0] PRESC_STEP   = PW'(3);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]  counter_q, counter_d;
  logic [CNT_WIDTH-1:0]  latch_q, latch_d;
  irq_ctrl_t             ctrl_q, ctrl_d;
  logic                  reloadFlag_q, reloadFlag_d;
  logic                  pending_q, pending_d;
  logic signed [PW-1:0]  presc_q, presc_d;
  logic signed [PW-1:0]  prescDec;
  logic [15:0]           latchWide;
  logic                  a12Tick;
  logic                  wrLatchLo, wrLatchHi, wrControl, wrReload, wrAck;
  logic                  setPending, clrPending;

  coolgirl_a12_filter #(
    .A12_FILTER(A12_FILTER)
  ) u_a12_filter (
    .m2_i  (m2),
    .rst_ni(rst_n),
    .a12_i (ppu_a12),
    .tick_o(a12Tick)
  );

  assign wrLatchLo = reg_we && (reg_sel == REG_LATCH_LO);
  assign wrLatchHi = reg_we && (reg_sel == REG_LATCH_HI);
  assign wrControl = reg_we && (reg_sel == REG_CONTROL);
  assign wrReload  = reg_we && (reg_sel == REG_RELOAD);
  assign wrAck     = reg_we && (reg_sel == REG_ACK);

  assign prescDec = presc_q - PRESC_STEP;

  // Counting uses the control value from before any same-cycle control write;
  // a same-cycle reload request always beats the tick it coincides with.
  always_comb begin
    counter_d    = counter_q;
    latch_d      = latch_q;
    ctrl_d       = ctrl_q;
    reloadFlag_d = reloadFlag_q;
    presc_d      = presc_q;
    setPending   = 1'b0;
    clrPending   = 1'b0;
    latchWide    = 16'(latch_q);

    if (wrLatchLo) latchWide[7:0]  = reg_wdata;
    if (wrLatchHi) latchWide[15:8] = reg_wdata;
    latch_d = latchWide[CNT_WIDTH-1:0];

    case (ctrl_q.mode)
      MODE_SCANLINE: begin
        if (wrReload) begin
          reloadFlag_d = 1'b1;
        end else if (a12Tick) begin
          if ((counter_q == '0) || reloadFlag_q) begin
            counter_d    = latch_q;
            reloadFlag_d = 1'b0;
          end else begin
            counter_d = counter_q - CNT_ONE;
          end
          if ((counter_d == '0) && ctrl_q.enable) setPending = 1'b1;
        end
      end
      MODE_CPU: begin
        if (wrReload) begin
          counter_d = latch_q;
          presc_d   = PRESC_RELOAD;
        end else if (ctrl_q.enable) begin
          if (counter_q != '0) begin
            counter_d = counter_q - CNT_ONE;
          end else begin
            setPending = 1'b1;
            if (ctrl_q.autoReload) counter_d = latch_q;
          end
        end
      end
      MODE_PRESCALED: begin
        if (wrReload) begin
          counter_d = latch_q;
          presc_d   = PRESC_RELOAD;
        end else if (ctrl_q.enable) begin
          presc_d = prescDec;
          if (prescDec[PW-1] || (prescDec == PW'(0))) begin
            presc_d = prescDec + PRESC_RELOAD;
            if (counter_q == '1) begin
              counter_d  = latch_q;
              setPending = 1'b1;
            end else begin
              counter_d = counter_q + CNT_ONE;
            end
          end
        end
      end
      default: begin
      end
    endcase

    if (wrControl) begin
      ctrl_d     = irq_ctrl_t'(reg_wdata[3:0]);
      clrPending = 1'b1;
      if (!reg_wdata[2]) presc_d = PRESC_RELOAD;
    end
    if (wrAck) clrPending = 1'b1;

    pending_d = pending_q;
    if (clrPending) pending_d = 1'b0;
    if (setPending) pending_d = 1'b1;
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      counter_q    <= '0;
      latch_q      <= '0;
      ctrl_q       <= '0;
      reloadFlag_q <= 1'b0;
      pending_q    <= 1'b0;
      presc_q      <= PRESC_RELOAD;
    end else begin
      counter_q    <= counter_d;
      latch_q      <= latch_d;
      ctrl_q       <= ctrl_d;
      reloadFlag_q <= reloadFlag_d;
      pending_q    <= pending_d;
      presc_q      <= presc_d;
    end
  end

  assign irq     = pending_q;
  assign counter = counter_q;

endmodule

// File: tb/tb_coolgirl_irq_unit.sv
// Directed self-checking bench for coolgirl_irq_unit with default parameters.
module tb_coolgirl_irq_unit;

  logic       m2;
  logic       rst_n;
  logic       reg_we;
  logic [2:0] reg_sel;
  logic [7:0] reg_wdata;
  logic       ppu_a12;
  logic       irq;
  logic [7:0] counter;

  int assertCount = 0;
  int failCount   = 0;

  coolgirl_irq_unit #(
    .CNT_WIDTH (8),
    .A12_FILTER(3),
    .PRESCALE  (341)
  ) dut (
    .m2       (m2),
    .rst_n    (rst_n),
    .reg_we   (reg_we),
    .reg_sel  (reg_sel),
    .reg_wdata(reg_wdata),
    .ppu_a12  (ppu_a12),
    .irq      (irq),
    .counter  (counter)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] data);
    reg_we    = 1'b1;
    reg_sel   = sel;
    reg_wdata = data;
    @(negedge m2);
    reg_we    = 1'b0;
    reg_sel   = 3'd7;
    reg_wdata = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge m2);
  endtask

  task automatic pulseA12(input int lowCycles);
    ppu_a12 = 1'b0;
    repeat (lowCycles) @(negedge m2);
    ppu_a12 = 1'b1;
    repeat (4) @(negedge m2);
  endtask

  task automatic checkState(input string tag, input logic [7:0] expCnt,
                            input logic expIrq);
    checkOutput({tag, "_cnt"}, 16'(counter), 16'(expCnt));
    checkOutput({tag, "_irq"}, 16'(irq), 16'(expIrq));
  endtask

  initial begin
    rst_n     = 1'b0;
    reg_we    = 1'b0;
    reg_sel   = 3'd7;
    reg_wdata = 8'h00;
    ppu_a12   = 1'b0;
    #1;
    checkState("reset", 8'd0, 1'b0);
    @(negedge m2);
    rst_n = 1'b1;
    idleCycles(2);

    // Scanline mode, latch 3
    applyStimulus(3'd0, 8'd3);
    checkState("latch_no_effect", 8'd0, 1'b0);
    applyStimulus(3'd2, 8'h04);
    pulseA12(4); checkState("m0_rise1", 8'd3, 1'b0);
    pulseA12(4); checkState("m0_rise2", 8'd2, 1'b0);
    pulseA12(4); checkState("m0_rise3", 8'd1, 1'b0);
    pulseA12(4); checkState("m0_rise4", 8'd0, 1'b1);
    pulseA12(4); checkState("m0_rise5", 8'd3, 1'b1);
    applyStimulus(3'd4, 8'h00);
    checkState("m0_ack", 8'd3, 1'b0);

    // Filter boundary: two low samples rejected, three accepted
    pulseA12(2); checkState("filt_low2", 8'd3, 1'b0);
    pulseA12(3); checkState("filt_low3", 8'd2, 1'b0);

    // Scanline reload request defers to next tick with the new latch
    applyStimulus(3'd0, 8'd5);
    applyStimulus(3'd3, 8'h00);
    checkState("m0_reload_req", 8'd2, 1'b0);
    pulseA12(4); checkState("m0_reload_tick", 8'd5, 1'b0);
    pulseA12(4); checkState("m0_after_reload", 8'd4, 1'b0);

    // CPU-cycle mode, latch 2, auto reload
    applyStimulus(3'd0, 8'd2);
    applyStimulus(3'd2, 8'h09);
    checkState("m1_setup", 8'd4, 1'b0);
    applyStimulus(3'd3, 8'h00);
    checkState("m1_reload", 8'd2, 1'b0);
    applyStimulus(3'd2, 8'h0D);
    checkState("m1_enable", 8'd2, 1'b0);
    idleCycles(1); checkState("m1_c1", 8'd1, 1'b0);
    idleCycles(1); checkState("m1_c2", 8'd0, 1'b0);
    idleCycles(1); checkState("m1_c3", 8'd2, 1'b1);
    idleCycles(1); checkState("m1_c4", 8'd1, 1'b1);
    applyStimulus(3'd4, 8'h00);
    checkState("m1_ack", 8'd0, 1'b0);
    applyStimulus(3'd4, 8'h00);
    checkState("m1_ack_vs_set", 8'd2, 1'b1);
    applyStimulus(3'd0, 8'd7);
    checkState("m1_latch7", 8'd1, 1'b1);
    applyStimulus(3'd3, 8'h00);
    checkState("m1_reload_vs_tick", 8'd7, 1'b1);

    // Frozen mode
    applyStimulus(3'd2, 8'h07);
    checkState("m3_enter", 8'd6, 1'b0);
    idleCycles(5);
    checkState("m3_frozen", 8'd6, 1'b0);

    // Prescaled mode, latch 0xFE
    applyStimulus(3'd0, 8'hFE);
    applyStimulus(3'd2, 8'h02);
    checkState("m2_setup", 8'd6, 1'b0);
    applyStimulus(3'd3, 8'h00);
    checkState("m2_reload", 8'hFE, 1'b0);
    applyStimulus(3'd2, 8'h06);
    idleCycles(113); checkState("m2_pre_tick1", 8'hFE, 1'b0);
    idleCycles(1);   checkState("m2_tick1", 8'hFF, 1'b0);
    idleCycles(113); checkState("m2_pre_tick2", 8'hFF, 1'b0);
    idleCycles(1);   checkState("m2_tick2", 8'hFE, 1'b1);
    applyStimulus(3'd4, 8'h00);
    checkState("m2_ack", 8'hFE, 1'b0);

    // Asynchronous reset mid-count
    #2;
    rst_n = 1'b0;
    #1;
    checkState("async_reset", 8'd0, 1'b0);
    @(negedge m2);
    rst_n = 1'b1;
    idleCycles(2);
    checkState("post_reset", 8'd0, 1'b0);
    applyStimulus(3'd0, 8'd4);
    pulseA12(2); checkState("post_reset_low2", 8'd0, 1'b0);
    pulseA12(3); checkState("post_reset_low3", 8'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/coolgirl_irq_unit.md
COOLGIRL_IRQ_UNIT -- requirements
Module: coolgirl_irq_unit

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, counter/latch width (8..16).
REQ-002 SHALL have parameter A12_FILTER, default 3, consecutive low m2 samples of A12 required before a rise counts.
REQ-003 SHALL have parameter PRESCALE, default 341, PPU dots per scanline for mode 2.
REQ-004 SHALL have port m2  in  1  CPU M2 clock; one clock, all logic on posedge m2.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port reg_we  in  1  register write strobe, one m2 cycle.
REQ-007 SHALL have port reg_sel  in  3  register index.
REQ-008 SHALL have port reg_wdata  in  8  write data.
REQ-009 SHALL have port ppu_a12  in  1  raw PPU A12, asynchronous to m2.
REQ-010 SHALL have port irq  out  1  IRQ request, active-high; top level inverts.
REQ-011 SHALL have port counter  out  CNT_WIDTH  current counter value.

Function
REQ-012 Registers: 0 latch[7:0]; 1 latch[CNT_WIDTH-1:8] (ignored if CNT_WIDTH=8); 2 control {auto_reload[3], enable[2], mode[1:0]}; 3 reload request (data ignored); 4 acknowledge (data ignored); 5-7 no effect.
REQ-013 Mode 0 (scanline): ppu_a12 through 2-flop synchroniser; tick = synchronised A12 high after >= A12_FILTER consecutive low samples.
REQ-014 Mode 0 tick: counter==0 or reload_flag -> counter<=latch, reload_flag<=0; else counter<=counter-1; if resulting value is 0 and enable, set pending.
REQ-015 Mode 1 (CPU cycle): every m2 with enable: counter!=0 -> decrement; counter==0 -> set pending, counter<=latch if auto_reload else hold 0.
REQ-016 Mode 2 (prescaled): prescaler decrements by 3 per m2 with enable; at <=0 adds PRESCALE and ticks; tick increments counter; all-ones -> counter<=latch, set pending.
REQ-017 Mode 3: counter and prescaler frozen, no ticks.
REQ-018 Reload request: mode 0 sets reload_flag; modes 1/2 load counter<=latch, prescaler<=PRESCALE immediately.
REQ-019 Write to control: clears pending; enable=0 also clears prescaler to PRESCALE.
REQ-020 Acknowledge write clears pending; clear and set in same cycle -> pending stays set.
REQ-021 Reload request and tick in same cycle: reload wins, tick discarded.
REQ-022 Latch writes take effect for the next reload; never alter counter directly.
REQ-023 irq = pending, registered, no combinational path from inputs.
REQ-024 Counter arithmetic modulo 2^CNT_WIDTH; prescaler signed, width ceil(log2(PRESCALE))+2.

Reset
REQ-025 rst_n low: counter=0, latch=0, control=0 (mode 0, disabled), reload_flag=0, pending=0, irq=0, prescaler=PRESCALE, filter count=0, synchronisers=0.
REQ-026 Reset mid-count SHALL abort immediately; first tick after release needs a full A12_FILTER low run.

Structure
REQ-027 Register indices and mode encodings SHALL live in shared package coolgirl_pkg.
REQ-028 A12 synchroniser + low-run filter SHALL be sub-module coolgirl_a12_filter; rest flat.

Verification
REQ-029 Mode 0, latch=3, enable: 5 filtered A12 rises -> counter 3,2,1,0(irq=1),3.
REQ-030 A12 pulses with only 2 low samples between rises (A12_FILTER=3) -> one tick only.
REQ-031 Mode 1, latch=2, auto_reload: irq asserts 3 m2 after enable, counter reloads to 2.
REQ-032 Mode 2, latch=0xFE: irq after 2 prescaler underflows (~228 m2); ack write -> irq=0 next cycle.
REQ-033 Ack write coinciding with new set -> irq stays 1; reload request coinciding with tick -> counter=latch.
REQ-034 rst_n pulsed low mid-count, asynchronous to m2 -> all outputs 0 immediately, counter 0.
